// File: rtl/window_linebuffer.sv
// Sliding KSIZE x KSIZE window over a raster stream using KSIZE+1 round-robin line memories.
// Window is combinational from the read pointers (zero latency); writes stall only when every line is full and unconsumed.
module window_linebuffer #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 512,
    parameter int KSIZE  = 3
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_data_valid,
    input  logic [DATA_W-1:0]               i_data,
    output logic                            o_in_ready,
    input  logic                            i_read_data,
    output logic [KSIZE*KSIZE*DATA_W-1:0]   o_window,
    output logic                            o_window_valid,
    output logic                            o_row_end
);

    localparam int NLINES = KSIZE + 1;
    localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RCOL_W = (IMG_W - KSIZE + 1 > 1) ? $clog2(IMG_W - KSIZE + 1) : 1;
    localparam int LINE_W = $clog2(NLINES);
    localparam int FILL_W = $clog2(NLINES + 1);

    localparam logic [0:0] ST_WAIT = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    logic [DATA_W-1:0] r_mem [NLINES][IMG_W];

    logic [COL_W-1:0]  r_wr_col;
    logic [LINE_W-1:0] r_wr_line;
    logic [RCOL_W-1:0] r_rd_col;
    logic [LINE_W-1:0] r_rd_line;
    logic [FILL_W-1:0] r_fill;
    logic [0:0]        r_state;

    logic              w_wr;
    logic              w_wr_wrap;
    logic              w_rd;
    logic              w_rd_end;
    logic [FILL_W-1:0] w_fill_nxt;
    logic [LINE_W-1:0] w_line_idx;
    logic [COL_W-1:0]  w_col_idx;

    assign o_in_ready     = (r_fill <= FILL_W'(KSIZE));
    assign o_window_valid = (r_state == ST_EMIT);
    assign o_row_end      = o_window_valid && (r_rd_col == RCOL_W'(IMG_W - KSIZE));

    assign w_wr      = i_data_valid && o_in_ready;
    assign w_wr_wrap = w_wr && (r_wr_col == COL_W'(IMG_W - 1));
    assign w_rd      = i_read_data && o_window_valid;
    assign w_rd_end  = w_rd && o_row_end;

    // A completed line and a consumed row in the same cycle cancel out.
    always_comb begin
        w_fill_nxt = r_fill;
        if (w_wr_wrap && !w_rd_end) begin
            w_fill_nxt = r_fill + FILL_W'(1);
        end else if (!w_wr_wrap && w_rd_end) begin
            w_fill_nxt = r_fill - FILL_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_line][r_wr_col] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_col  <= '0;
            r_wr_line <= '0;
            r_rd_col  <= '0;
            r_rd_line <= '0;
            r_fill    <= '0;
            r_state   <= ST_WAIT;
        end else begin
            if (w_wr) begin
                if (w_wr_wrap) begin
                    r_wr_col  <= '0;
                    r_wr_line <= (r_wr_line == LINE_W'(KSIZE)) ? '0 : r_wr_line + LINE_W'(1);
                end else begin
                    r_wr_col  <= r_wr_col + COL_W'(1);
                end
            end
            if (w_rd) begin
                if (w_rd_end) begin
                    r_rd_col  <= '0;
                    r_rd_line <= (r_rd_line == LINE_W'(KSIZE)) ? '0 : r_rd_line + LINE_W'(1);
                end else begin
                    r_rd_col  <= r_rd_col + RCOL_W'(1);
                end
            end
            r_fill  <= w_fill_nxt;
            r_state <= (w_fill_nxt >= FILL_W'(KSIZE)) ? ST_EMIT : ST_WAIT;
        end
    end

    // Oldest line and leftmost column land in the most significant slot.
    always_comb begin
        o_window   = '0;
        w_line_idx = '0;
        w_col_idx  = '0;
        if (o_window_valid) begin
            for (int r = 0; r < KSIZE; r++) begin
                for (int c = 0; c < KSIZE; c++) begin
                    w_line_idx = LINE_W'((int'(r_rd_line) + r) % NLINES);
                    w_col_idx  = COL_W'(int'(r_rd_col) + c);
                    o_window[(KSIZE*KSIZE-1-(r*KSIZE+c))*DATA_W +: DATA_W] = r_mem[w_line_idx][w_col_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_window_linebuffer.sv
// Bench for window_linebuffer at IMG_W=8, KSIZE=3; pixel value encodes (line*16 + col).
module tb_window_linebuffer;

    localparam int DW = 8;
    localparam int IW = 8;
    localparam int K  = 3;
    localparam int WW = K*K*DW;

    logic          clk;
    logic          rst_n;
    logic          data_valid;
    logic [DW-1:0] data;
    logic          in_ready;
    logic          read_data;
    logic [WW-1:0] window;
    logic          window_valid;
    logic          row_end;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int base;
        int col;
        bit row_end;
    } vec_t;
    vec_t tab[6];

    logic [WW:0] sb_q[$];

    window_linebuffer #(.DATA_W(DW), .IMG_W(IW), .KSIZE(K)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_data_valid   (data_valid),
        .i_data         (data),
        .o_in_ready     (in_ready),
        .i_read_data    (read_data),
        .o_window       (window),
        .o_window_valid (window_valid),
        .o_row_end      (row_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    function automatic logic [DW-1:0] pix(input int l, input int c);
        return DW'(l*16 + c);
    endfunction

    function automatic logic [WW-1:0] exp_win(input int base, input int col);
        logic [WW-1:0] w;
        w = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                w[(K*K-1-(r*K+c))*DW +: DW] = pix(base + r, col + c);
            end
        end
        return w;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_window(input string name, input int base, input int col, input bit re);
        logic [WW:0] e;
        sb_q.push_back({exp_win(base, col), re});
        chk1({name, "_valid"}, window_valid, 1'b1);
        e = sb_q.pop_front();
        chkw({name, "_win"}, window, e[WW:1]);
        chk1({name, "_row_end"}, row_end, e[0]);
    endtask

    task automatic reset_checks(input string name);
        chk1({name, "_valid"}, window_valid, 1'b0);
        chk1({name, "_row_end"}, row_end, 1'b0);
        chkw({name, "_win"}, window, '0);
        chk1({name, "_in_ready"}, in_ready, 1'b1);
    endtask

    task automatic wr(input logic [DW-1:0] v);
        data_valid = 1'b1;
        data       = v;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
    endtask

    task automatic rd_pulse();
        read_data = 1'b1;
        @(posedge clk);
        #1;
        read_data = 1'b0;
    endtask

    task automatic wr_and_rd(input logic [DW-1:0] v);
        data_valid = 1'b1;
        data       = v;
        read_data  = 1'b1;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        read_data  = 1'b0;
    endtask

    initial begin
        tab[0] = '{0, 0, 1'b0};
        tab[1] = '{0, 1, 1'b0};
        tab[2] = '{0, 2, 1'b0};
        tab[3] = '{0, 3, 1'b0};
        tab[4] = '{0, 4, 1'b0};
        tab[5] = '{0, 5, 1'b1};

        rst_n      = 1'b1;
        data_valid = 1'b0;
        data       = '0;
        read_data  = 1'b0;
        #2 rst_n = 1'b0;
        #1 reset_checks("rst_init");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill three lines, then walk the first row.
        for (int i = 0; i < 24; i++) begin
            if (i == 23) chk1("valid_before_24th", window_valid, 1'b0);
            wr(pix(i/8, i%8));
        end
        for (int i = 0; i < 6; i++) begin
            check_window($sformatf("row0_col%0d", tab[i].col), tab[i].base, tab[i].col, tab[i].row_end);
            rd_pulse();
        end
        chk1("valid_after_row0", window_valid, 1'b0);
        chkw("win_zero_when_invalid", window, '0);
        chk1("row_end_when_invalid", row_end, 1'b0);
        rd_pulse();
        chk1("read_ignored_when_invalid", window_valid, 1'b0);

        // Fill all four lines; the extra write must be dropped.
        @(negedge clk);
        rst_n = 1'b0;
        #1 reset_checks("rst_b");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i == 31) chk1("in_ready_before_32nd", in_ready, 1'b1);
            wr(pix(i/8, i%8));
        end
        chk1("in_ready_after_32nd", in_ready, 1'b0);
        wr(8'hEE);
        chk1("in_ready_after_drop", in_ready, 1'b0);
        check_window("after_drop", 0, 0, 1'b0);
        for (int i = 0; i < 6; i++) rd_pulse();
        check_window("row1_start", 1, 0, 1'b0);
        chk1("in_ready_fill3", in_ready, 1'b1);

        // Line completion coinciding with the row-ending read.
        for (int i = 0; i < 7; i++) wr(pix(4, i));
        for (int i = 0; i < 5; i++) rd_pulse();
        check_window("pre_coincide", 1, 5, 1'b1);
        wr_and_rd(pix(4, 7));
        check_window("coincide", 2, 0, 1'b0);
        chk1("coincide_in_ready", in_ready, 1'b1);

        // Asynchronous reset in the middle of a row.
        rd_pulse();
        rd_pulse();
        check_window("mid_row", 2, 2, 1'b0);
        #2 rst_n = 1'b0;
        #1 reset_checks("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if (i == 23) chk1("refill_valid_before_24th", window_valid, 1'b0);
            wr(pix(i/8, i%8));
        end
        check_window("refill", 0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
